hazard_unit: RTL and testbench

Pipeline hazard unit for the five-stage MIPS core. It consumes the per-stage control and register-address signals that the controller and datapath produce, and returns the stall, flush and forwarding controls they consume, including `Flush_E` for the controller's E-stage register. It also contains a wait-state machine for a data memory with a ready handshake, plus saturating stall and flush counters for performance measurement.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/mem_wait_fsm.sv | 36 +++
 rtl/hazard_unit.sv | 74 +++++++
 tb/tb_hazard_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: forward encodings, wait-FSM state type and register-match helpers
package hazard_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic {IDLE, WAIT} mem_state_t;
  function automatic logic hit(input logic en, input logic [4:0] wr, input logic [4:0] src);
    return en && (wr != 5'd0) && (wr == src);
  endfunction
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic rw_m, input logic [4:0] wr_m,
                                         input logic rw_w, input logic [4:0] wr_w);
    return hit(rw_m, wr_m, src) ? FWD_MEM : hit(rw_w, wr_w, src) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: data-memory wait states; in clk/rst/i_access/i_ready, out o_memstall (comb), o_error (sticky timeout)
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_access,
  input  logic i_ready,
  output logic o_memstall,
  output logic o_error
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  mem_state_t     r_state;
  logic [CW-1:0]  r_wait_cnt;
  logic           r_error;
  logic           w_sat;
  assign o_memstall = i_access & ~i_ready;
  assign o_error    = r_error;
  assign w_sat      = r_wait_cnt == CW'(MEM_TIMEOUT);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_error    <= 1'b0;
    end else if (r_state == IDLE || !o_memstall) begin
      r_state    <= (r_state == IDLE && o_memstall) ? WAIT : IDLE;
      r_wait_cnt <= '0;
    end else begin
      // error rises on the same edge the count reaches the timeout
      r_wait_cnt <= w_sat ? r_wait_cnt : r_wait_cnt + 1'b1;
      r_error    <= r_error | (r_wait_cnt == CW'(MEM_TIMEOUT - 1)) | w_sat;
    end
  end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: MIPS stall/flush/forward control; in D/E/M/W reg addrs and ctrl, out stalls, flushes, forwards, perf counters, mem error
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_rs_d,
  input  logic [4:0]       i_rt_d,
  input  logic             i_branch_d,
  input  logic [4:0]       i_rs_e,
  input  logic [4:0]       i_rt_e,
  input  logic [4:0]       i_write_reg_e,
  input  logic [4:0]       i_write_reg_m,
  input  logic [4:0]       i_write_reg_w,
  input  logic             i_reg_write_e,
  input  logic             i_reg_write_m,
  input  logic             i_reg_write_w,
  input  logic             i_mem_to_reg_e,
  input  logic             i_mem_to_reg_m,
  input  logic             i_mem_write_m,
  input  logic             i_mem_ready_m,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_stall_e,
  output logic             o_stall_m,
  output logic             o_flush_e,
  output logic             o_flush_w,
  output logic             o_forward_a_d,
  output logic             o_forward_b_d,
  output logic [1:0]       o_forward_a_e,
  output logic [1:0]       o_forward_b_e,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count,
  output logic             o_mem_error
);
  logic             w_lwstall, w_brstall, w_memstall;
  logic [CNT_W-1:0] r_stall_count, r_flush_count;
  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_access  (i_mem_to_reg_m | i_mem_write_m),
    .i_ready   (i_mem_ready_m),
    .o_memstall(w_memstall),
    .o_error   (o_mem_error)
  );
  assign o_forward_a_e = fwd_sel(i_rs_e, i_reg_write_m, i_write_reg_m, i_reg_write_w, i_write_reg_w);
  assign o_forward_b_e = fwd_sel(i_rt_e, i_reg_write_m, i_write_reg_m, i_reg_write_w, i_write_reg_w);
  assign o_forward_a_d = hit(i_reg_write_m, i_write_reg_m, i_rs_d);
  assign o_forward_b_d = hit(i_reg_write_m, i_write_reg_m, i_rt_d);
  assign w_lwstall = hit(i_mem_to_reg_e, i_write_reg_e, i_rs_d) | hit(i_mem_to_reg_e, i_write_reg_e, i_rt_d);
  assign w_brstall = i_branch_d & (hit(i_reg_write_e, i_write_reg_e, i_rs_d) | hit(i_reg_write_e, i_write_reg_e, i_rt_d) |
                                   hit(i_mem_to_reg_m, i_write_reg_m, i_rs_d) | hit(i_mem_to_reg_m, i_write_reg_m, i_rt_d));
  assign o_stall_f = w_lwstall | w_brstall | w_memstall;
  assign o_stall_d = o_stall_f;
  assign o_stall_e = w_memstall;
  assign o_stall_m = w_memstall;
  assign o_flush_w = w_memstall;
  // a memory stall freezes E, so the dependency bubble waits until memory completes
  assign o_flush_e = (w_lwstall | w_brstall) & ~w_memstall;
  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_stall_count <= r_stall_count + CNT_W'(o_stall_f & ~&r_stall_count);
      r_flush_count <= r_flush_count + CNT_W'(o_flush_e & ~&r_flush_count);
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scoreboard bench for hazard_unit (CNT_W=4, MEM_TIMEOUT=4)
module tb_hazard_unit;
  import hazard_pkg::*;
  logic       clk = 1'b0, rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic       branch_d, rw_e, rw_m, rw_w, mtr_e, mtr_m, mw_m, ready_m;
  logic       stall_f, stall_d, stall_e, stall_m, flush_e, flush_w, fad, fbd, mem_error;
  logic [1:0] fae, fbe;
  logic [3:0] stall_count, flush_count;
  logic [11:0] obs;
  typedef struct {string tag; logic [11:0] exp;} sb_t;
  sb_t q[$];
  int total = 0, bad = 0;
  hazard_unit #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .i_rs_d(rs_d), .i_rt_d(rt_d), .i_branch_d(branch_d),
    .i_rs_e(rs_e), .i_rt_e(rt_e), .i_write_reg_e(wr_e), .i_write_reg_m(wr_m), .i_write_reg_w(wr_w),
    .i_reg_write_e(rw_e), .i_reg_write_m(rw_m), .i_reg_write_w(rw_w),
    .i_mem_to_reg_e(mtr_e), .i_mem_to_reg_m(mtr_m), .i_mem_write_m(mw_m), .i_mem_ready_m(ready_m),
    .o_stall_f(stall_f), .o_stall_d(stall_d), .o_stall_e(stall_e), .o_stall_m(stall_m),
    .o_flush_e(flush_e), .o_flush_w(flush_w), .o_forward_a_d(fad), .o_forward_b_d(fbd),
    .o_forward_a_e(fae), .o_forward_b_e(fbe), .o_stall_count(stall_count), .o_flush_count(flush_count),
    .o_mem_error(mem_error)
  );
  always #5 clk = ~clk;
  assign obs = {stall_f, stall_d, stall_e, stall_m, flush_e, flush_w, fad, fbd, fae, fbe};
  function automatic logic [11:0] ev(input logic sf, sd, se, sm, fe, fw, ad, bd, input logic [1:0] ae, be);
    return {sf, sd, se, sm, fe, fw, ad, bd, ae, be};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic step(input string tag, input logic [11:0] e);
    sb_t s;
    q.push_back('{tag, e});
    #2;
    s = q.pop_front();
    chk(s.tag, 32'(obs), 32'(s.exp));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w} = '0;
    {branch_d, rw_e, rw_m, rw_w, mtr_e, mtr_m, mw_m} = '0;
    ready_m = 1'b1;
  endtask
  task automatic chk_regs(input string tag, input logic [3:0] sc, input logic [3:0] fc, input logic err, input mem_state_t st);
    chk({tag, "_scnt"}, 32'(stall_count), 32'(sc));
    chk({tag, "_fcnt"}, 32'(flush_count), 32'(fc));
    chk({tag, "_err"}, 32'(mem_error), 32'(err));
    chk({tag, "_st"}, 32'(dut.u_fsm.r_state), 32'(st));
  endtask
  initial begin
    rst = 1'b1;
    clr();
    tick();
    mtr_e = 1'b1; wr_e = 5'd9; rt_d = 5'd9;
    step("rst_comb", ev(1, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    tick();
    chk_regs("rst", 4'd0, 4'd0, 1'b0, IDLE);
    rst = 1'b0;
    clr();
    rw_m = 1'b1; wr_m = 5'd8; rs_e = 5'd8;
    step("alu_m", ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00));
    tick();
    rw_w = 1'b1; wr_w = 5'd8; rt_e = 5'd8;
    step("alu_mw", ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10));
    tick();
    rw_m = 1'b0;
    step("alu_w", ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01));
    tick();
    clr();
    rw_m = 1'b1; rw_w = 1'b1; rw_e = 1'b1; mtr_e = 1'b1; mtr_m = 1'b1; branch_d = 1'b1;
    step("r0", ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    tick();
    clr();
    rw_m = 1'b1; wr_m = 5'd5; rs_d = 5'd5; rt_d = 5'd6;
    step("fwd_d", ev(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00));
    tick();
    chk_regs("nostall", 4'd0, 4'd0, 1'b0, IDLE);
    clr();
    mtr_e = 1'b1; rw_e = 1'b1; wr_e = 5'd9; rt_d = 5'd9;
    step("loaduse", ev(1, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    tick();
    clr();
    step("lu_after", ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    chk_regs("lu", 4'd1, 4'd1, 1'b0, IDLE);
    branch_d = 1'b1; rw_e = 1'b1; wr_e = 5'd3; rs_d = 5'd3;
    step("br_e", ev(1, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    tick();
    chk_regs("br_e", 4'd2, 4'd2, 1'b0, IDLE);
    clr();
    branch_d = 1'b1; mtr_m = 1'b1; rw_m = 1'b1; wr_m = 5'd3; rs_d = 5'd3;
    step("br_m", ev(1, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00));
    tick();
    chk_regs("br_m", 4'd3, 4'd3, 1'b0, IDLE);
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clr();
      mtr_m = 1'b1; ready_m = 1'b0; mtr_e = 1'b1; wr_e = 5'd9; rt_d = 5'd9;
      step("memwait", ev(1, 1, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00));
      tick();
      chk("memwait_st", 32'(dut.u_fsm.r_state), 32'(WAIT));
    end
    ready_m = 1'b1;
    step("memdone", ev(1, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    tick();
    chk_regs("memdone", 4'd4, 4'd1, 1'b0, IDLE);
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mtr_m = 1'b1; ready_m = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("timeout_err", 32'(mem_error), 32'(k >= 4));
    end
    ready_m = 1'b1;
    tick();
    chk_regs("timeout_done", 4'd6, 4'd0, 1'b1, IDLE);
    clr();
    rst = 1'b1;
    tick();
    chk_regs("timeout_rst", 4'd0, 4'd0, 1'b0, IDLE);
    rst = 1'b0;
    mtr_e = 1'b1; wr_e = 5'd9; rt_d = 5'd9;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) chk("sat14", 32'(stall_count), 32'd14);
      if (k == 15) chk("sat15", 32'(stall_count), 32'd15);
    end
    chk_regs("sat20", 4'd15, 4'd15, 1'b0, IDLE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
